conv2d_sched: RTL and testbench
===============================

CONV2D_SCHED -- requirements
Module: conv2d_sched

Interface
REQ-001 Parameters SHALL be: C_WIDTH, default 9, image width bits; C_LENGTH, default 18, pixel-count bits; KS, default 3, kernel size; C_CH, default 8, channel-count bits; C_WA, default 16, weight-address bits.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  cfg_start  in  1  one-cycle layer start pulse, accepted only in IDLE
  cfg_abort  in  1  synchronous abort, any state
  cfg_width  in  C_WIDTH  image width
  cfg_length  in  C_LENGTH  pixels per map
  cfg_in_ch  in  C_CH  input-channel count
  cfg_out_ch  in  C_CH  output-channel count
  busy  out  1  high outside IDLE
  done  out  1  one-cycle layer-complete pulse
  wgt_req  out  1  weight fetch request, level
  wgt_addr  out  C_WA  kernel index
  wgt_vld  in  1  one-cycle response, weight data valid
  wgt_data  in  KS*KS*32  kernel weights
  param_ena  out  1  core parameter load strobe
  param_weight  out  KS*KS*32  registered kernel
  param_width  out  C_WIDTH  registered width
  param_length  out  C_LENGTH  registered length
  src_ready  in  1  pixel source can stream channel src_ch
  src_ch  out  C_CH  input channel to stream
  pxl_ena_x  out  1  pass start pulse to core and source
  core_ena_y  in  1  core partial-sum read request
  core_pxl_y  out  32  partial sum to core
  core_ena_z  in  1  core result valid
  acc_rd_en  out  1  accumulator read strobe
  acc_rd_addr  out  C_LENGTH  accumulator read address
  acc_rdata  in  32  accumulator data, valid the cycle after acc_rd_en
  acc_wr_en  out  1  accumulator write strobe
  acc_wr_addr  out  C_LENGTH  accumulator write address
  out_en  out  1  final-result strobe to downstream
  out_oc  out  C_CH  output channel of out_en beats

Function
REQ-003 FSM states SHALL be IDLE, FETCH, LOAD, WAITSRC, START, DRAIN, NEXT, FIN.
REQ-004 IDLE->FETCH on cfg_start with cfg_in_ch and cfg_out_ch both nonzero; on cfg_start with either zero, IDLE->FIN directly, issuing no fetch and no pass.
REQ-005 cfg_width/length/in_ch/out_ch SHALL be latched on accepted cfg_start; later changes are ignored until the next layer.
REQ-006 FETCH: wgt_req=1 and wgt_addr = running kernel index (0 at layer start, +1 per NEXT, no multiplier); on wgt_vld register wgt_data, drop wgt_req the next cycle, go to LOAD.
REQ-007 LOAD: param_ena=1 for exactly one cycle with stable param_* values; go to WAITSRC.
REQ-008 WAITSRC: src_ch = ic; on src_ready go to START.
REQ-009 START: pxl_ena_x=1 for exactly one cycle; clear z-beat counter and both acc address counters; go to DRAIN.
REQ-010 core_pxl_y SHALL be 32'd0 when ic==0, else acc_rdata.
REQ-011 acc_rd_en SHALL equal core_ena_y when ic!=0, else 0; acc_rd_addr increments after each core_ena_y beat.
REQ-012 On core_ena_z: if ic != in_ch-1, acc_wr_en=1 at acc_wr_addr; else out_en=1 with out_oc=oc and acc_wr_en=0; acc_wr_addr increments per beat.
REQ-013 DRAIN ends when the z-beat counter reaches cfg_length; state SHALL go to NEXT the following cycle; core_ena_z outside DRAIN is ignored.
REQ-014 NEXT: ic+1; if ic wraps past in_ch-1, ic=0 and oc+1; if oc wraps past out_ch-1, go to FIN, else FETCH.
REQ-015 FIN: done=1 for one cycle; go to IDLE.
REQ-016 cfg_abort SHALL force IDLE next cycle, deassert every strobe, suppress done, and take priority over all other transitions; cfg_start during abort is ignored.
REQ-017 Counters SHALL not overflow: ic/oc are C_CH bits, z counter is C_LENGTH bits compared with equality.

Reset
REQ-018 On rst_n low, state SHALL be IDLE and busy, done, wgt_req, param_ena, pxl_ena_x, acc_rd_en, acc_wr_en, out_en SHALL be 0; all addresses, counters, src_ch, out_oc and param_* SHALL be 0.
REQ-019 Reset asserted mid-pass SHALL abandon the pass; no strobe asserts until a new cfg_start after rst_n rises.

Verification
REQ-020 in_ch=1, out_ch=1, length=16, wgt_vld after 3 cycles -> one param_ena, one pxl_ena_x, 16 out_en beats with core_pxl_y=0, done once, zero acc writes.
REQ-021 in_ch=3, out_ch=2, length=4 -> wgt_addr 0..5 in order; per oc: 8 acc writes with addresses 0..3 twice, then 4 out_en beats; done after the 24th core_ena_z beat.
REQ-022 in_ch=0, out_ch=5 -> done one cycle after FIN entry, busy high 1 cycle, no wgt_req.
REQ-023 cfg_abort during DRAIN of pass 2 -> IDLE next cycle, done never pulses, new cfg_start runs from wgt_addr 0.
REQ-024 rst_n low while wgt_req high -> all outputs 0 immediately (asynchronous), IDLE held after release.
REQ-025 src_ready held low 50 cycles in WAITSRC -> pxl_ena_x stays 0, fires exactly once, 1 cycle after src_ready rises.

Source files
------------

// File: rtl/conv2d_sched.sv
// rtl/conv2d_sched.sv - layer scheduler for a 2-D convolution core
//
// Walks every (output channel, input channel) pair of a layer. For each pair
// it fetches one kernel, loads it into the core, waits for the pixel source,
// starts one pass and routes the pass's partial sums through an external
// accumulator. The last input channel of each output channel streams its
// results downstream instead of writing them back.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_start/cfg_abort           layer start pulse (IDLE only), synchronous abort
//   cfg_width/length/in_ch/out_ch layer shape, latched on accepted start
//   busy, done                    status level, layer-complete pulse
//   wgt_req/wgt_addr/wgt_vld/wgt_data   kernel fetch handshake
//   param_ena/param_weight/param_width/param_length   core parameter load
//   src_ready, src_ch             pixel source handshake
//   pxl_ena_x                     pass start pulse
//   core_ena_y, core_pxl_y        core partial-sum read request and data
//   core_ena_z                    core result valid
//   acc_rd_en/acc_rd_addr/acc_rdata     accumulator read port
//   acc_wr_en/acc_wr_addr         accumulator write port
//   out_en, out_oc                final-result strobe and its output channel
module conv2d_sched #(
  parameter int C_WIDTH  = 9,
  parameter int C_LENGTH = 18,
  parameter int KS       = 3,
  parameter int C_CH     = 8,
  parameter int C_WA     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [C_WIDTH-1:0]     cfg_width,
  input  logic [C_LENGTH-1:0]    cfg_length,
  input  logic [C_CH-1:0]        cfg_in_ch,
  input  logic [C_CH-1:0]        cfg_out_ch,
  output logic                   busy,
  output logic                   done,
  output logic                   wgt_req,
  output logic [C_WA-1:0]        wgt_addr,
  input  logic                   wgt_vld,
  input  logic [KS*KS*32-1:0]    wgt_data,
  output logic                   param_ena,
  output logic [KS*KS*32-1:0]    param_weight,
  output logic [C_WIDTH-1:0]     param_width,
  output logic [C_LENGTH-1:0]    param_length,
  input  logic                   src_ready,
  output logic [C_CH-1:0]        src_ch,
  output logic                   pxl_ena_x,
  input  logic                   core_ena_y,
  output logic [31:0]            core_pxl_y,
  input  logic                   core_ena_z,
  output logic                   acc_rd_en,
  output logic [C_LENGTH-1:0]    acc_rd_addr,
  input  logic [31:0]            acc_rdata,
  output logic                   acc_wr_en,
  output logic [C_LENGTH-1:0]    acc_wr_addr,
  output logic                   out_en,
  output logic [C_CH-1:0]        out_oc
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAITSRC, START, DRAIN, NEXT, FIN
  } state_t;

  localparam logic [C_CH-1:0]     CH_ONE  = C_CH'(1);
  localparam logic [C_LENGTH-1:0] LEN_ONE = C_LENGTH'(1);
  localparam logic [C_WA-1:0]     WA_ONE  = C_WA'(1);

  state_t                state;
  logic [C_WIDTH-1:0]    width_q;
  logic [C_LENGTH-1:0]   len_q;
  logic [C_CH-1:0]       in_ch_q;
  logic [C_CH-1:0]       out_ch_q;
  logic [C_CH-1:0]       ic;
  logic [C_CH-1:0]       oc;
  logic [C_WA-1:0]       kidx;
  logic [C_LENGTH-1:0]   z_cnt;
  logic [C_LENGTH-1:0]   rd_addr;
  logic [C_LENGTH-1:0]   wr_addr;

  logic                  last_ic;
  logic                  last_oc;
  logic                  in_drain;
  logic                  z_take;
  logic [C_LENGTH-1:0]   z_next;

  assign last_ic  = (ic == in_ch_q - CH_ONE);
  assign last_oc  = (oc == out_ch_q - CH_ONE);
  // An abort in the same cycle silences every datapath strobe at once.
  assign in_drain = (state == DRAIN) && !cfg_abort;
  // Beats past the pass length are dropped so z_cnt can never run beyond it.
  assign z_take   = in_drain && core_ena_z && (z_cnt != len_q);
  assign z_next   = z_take ? (z_cnt + LEN_ONE) : z_cnt;

  assign busy        = (state != IDLE);
  assign wgt_addr    = kidx;
  assign src_ch      = ic;
  assign out_oc      = oc;
  assign acc_rd_addr = rd_addr;
  assign acc_wr_addr = wr_addr;

  // The first input channel starts from zero; later ones add onto the
  // partial sums stored by the previous pass.
  assign core_pxl_y = (ic == '0) ? 32'd0 : acc_rdata;
  assign acc_rd_en  = in_drain && core_ena_y && (ic != '0);
  assign acc_wr_en  = z_take && !last_ic;
  assign out_en     = z_take && last_ic;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      width_q      <= '0;
      len_q        <= '0;
      in_ch_q      <= '0;
      out_ch_q     <= '0;
      ic           <= '0;
      oc           <= '0;
      kidx         <= '0;
      z_cnt        <= '0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      done         <= 1'b0;
      wgt_req      <= 1'b0;
      param_ena    <= 1'b0;
      pxl_ena_x    <= 1'b0;
      param_weight <= '0;
      param_width  <= '0;
      param_length <= '0;
    end else begin
      param_ena <= 1'b0;
      pxl_ena_x <= 1'b0;
      done      <= 1'b0;
      if (cfg_abort) begin
        state   <= IDLE;
        wgt_req <= 1'b0;
        ic      <= '0;
        oc      <= '0;
        kidx    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              width_q  <= cfg_width;
              len_q    <= cfg_length;
              in_ch_q  <= cfg_in_ch;
              out_ch_q <= cfg_out_ch;
              ic       <= '0;
              oc       <= '0;
              kidx     <= '0;
              // An empty layer completes without touching the core.
              if (cfg_in_ch != '0 && cfg_out_ch != '0) begin
                state   <= FETCH;
                wgt_req <= 1'b1;
              end else begin
                state <= FIN;
              end
            end
          end
          FETCH: begin
            if (wgt_vld) begin
              param_weight <= wgt_data;
              param_width  <= width_q;
              param_length <= len_q;
              wgt_req      <= 1'b0;
              param_ena    <= 1'b1;
              state        <= LOAD;
            end
          end
          LOAD: state <= WAITSRC;
          WAITSRC: begin
            if (src_ready) begin
              pxl_ena_x <= 1'b1;
              state     <= START;
            end
          end
          START: begin
            z_cnt   <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            state   <= DRAIN;
          end
          DRAIN: begin
            if (core_ena_y) rd_addr <= rd_addr + LEN_ONE;
            if (z_take) begin
              z_cnt   <= z_next;
              wr_addr <= wr_addr + LEN_ONE;
            end
            if (z_next == len_q) state <= NEXT;
          end
          NEXT: begin
            kidx <= kidx + WA_ONE;
            if (last_ic) begin
              ic <= '0;
              if (last_oc) begin
                state <= FIN;
              end else begin
                oc      <= oc + CH_ONE;
                state   <= FETCH;
                wgt_req <= 1'b1;
              end
            end else begin
              ic      <= ic + CH_ONE;
              state   <= FETCH;
              wgt_req <= 1'b1;
            end
          end
          FIN: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv2d_sched.sv
// tb/tb_conv2d_sched.sv - directed self-checking bench for conv2d_sched
module tb_conv2d_sched;
  localparam int C_WIDTH  = 9;
  localparam int C_LENGTH = 18;
  localparam int KS       = 3;
  localparam int C_CH     = 8;
  localparam int C_WA     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_start, cfg_abort;
  logic [C_WIDTH-1:0]   cfg_width;
  logic [C_LENGTH-1:0]  cfg_length;
  logic [C_CH-1:0]      cfg_in_ch, cfg_out_ch;
  logic                 busy, done, wgt_req, wgt_vld, param_ena;
  logic [C_WA-1:0]      wgt_addr;
  logic [KS*KS*32-1:0]  wgt_data, param_weight;
  logic [C_WIDTH-1:0]   param_width;
  logic [C_LENGTH-1:0]  param_length;
  logic                 src_ready, pxl_ena_x, core_ena_y, core_ena_z;
  logic [C_CH-1:0]      src_ch, out_oc;
  logic [31:0]          core_pxl_y, acc_rdata;
  logic                 acc_rd_en, acc_wr_en, out_en;
  logic [C_LENGTH-1:0]  acc_rd_addr, acc_wr_addr;

  always #5 clk = ~clk;

  conv2d_sched #(
    .C_WIDTH(C_WIDTH), .C_LENGTH(C_LENGTH), .KS(KS), .C_CH(C_CH), .C_WA(C_WA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_width(cfg_width), .cfg_length(cfg_length), .cfg_in_ch(cfg_in_ch),
    .cfg_out_ch(cfg_out_ch), .busy(busy), .done(done), .wgt_req(wgt_req),
    .wgt_addr(wgt_addr), .wgt_vld(wgt_vld), .wgt_data(wgt_data),
    .param_ena(param_ena), .param_weight(param_weight), .param_width(param_width),
    .param_length(param_length), .src_ready(src_ready), .src_ch(src_ch),
    .pxl_ena_x(pxl_ena_x), .core_ena_y(core_ena_y), .core_pxl_y(core_pxl_y),
    .core_ena_z(core_ena_z), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
    .acc_rdata(acc_rdata), .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .out_en(out_en), .out_oc(out_oc)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cnt_wreq, cnt_param, cnt_pxl, cnt_wr, cnt_out, cnt_z, cnt_done, cnt_rd, done_z;
  int cur_in = 1, cur_out = 1, cur_len = 1, cur_ic = 0, cur_oc = 0;
  int pass_n = 0, beat = 0, rd_beat = 0, exp_kidx = 0;
  int wgt_delay = 3;
  bit mon_en = 1'b1;
  logic wgt_req_d = 1'b0;
  logic rd_pend = 1'b0;
  logic [C_LENGTH-1:0] rd_pend_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    cnt_wreq = 0; cnt_param = 0; cnt_pxl = 0; cnt_wr = 0; cnt_out = 0;
    cnt_z = 0; cnt_done = 0; cnt_rd = 0; done_z = -1;
  endtask

  // Called right after a posedge; returns just after the accepting edge.
  task automatic start_layer(input int n_in, input int n_out, input int len);
    cur_in = n_in; cur_out = n_out; cur_len = len;
    exp_kidx = 0; pass_n = 0; beat = 0; rd_beat = 0;
    clr_counts();
    cfg_width  = 9'd100;
    cfg_length = C_LENGTH'(len);
    cfg_in_ch  = C_CH'(n_in);
    cfg_out_ch = C_CH'(n_out);
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
    // Scramble the config; the running layer must keep its latched copy.
    cfg_width  = 9'h1FF;
    cfg_length = 18'd3;
    cfg_in_ch  = 8'd9;
    cfg_out_ch = 8'd9;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (cnt_done == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 64'(cnt_done != 0), 64'd1);
    tick();
    tick();
  endtask

  // Weight memory: answers wgt_req after wgt_delay cycles.
  initial begin
    int wc = 0;
    wgt_vld  = 1'b0;
    wgt_data = '0;
    forever begin
      tick();
      wgt_vld = 1'b0;
      if (wgt_req) begin
        wc++;
        if (wc >= wgt_delay) begin
          wgt_data        = '0;
          wgt_data[31:0]  = {16'hBEEF, wgt_addr};
          wgt_vld         = 1'b1;
          wc              = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Accumulator memory: data one cycle after a read, tagged with its address.
  initial begin
    acc_rdata = 32'hFFFF_FFFF;
    forever begin
      tick();
      acc_rdata = rd_pend ? {14'h1400, rd_pend_addr} : 32'hFFFF_FFFF;
    end
  end

  // Core: after a pass start, alternates one y request and one z result per pixel.
  initial begin
    core_ena_y = 1'b0;
    core_ena_z = 1'b0;
    forever begin
      tick();
      if (pxl_ena_x) begin
        tick();
        for (int i = 0; i < cur_len; i++) begin
          core_ena_y = 1'b1;
          tick();
          core_ena_y = 1'b0;
          core_ena_z = 1'b1;
          tick();
          core_ena_z = 1'b0;
        end
      end
    end
  end

  // Event monitor and per-beat scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wgt_req && !wgt_req_d) begin
          cnt_wreq++;
          if (mon_en) check("wgt_addr", 64'(wgt_addr), 64'(exp_kidx));
          exp_kidx++;
        end
        if (param_ena) begin
          cnt_param++;
          if (mon_en) begin
            check("param_weight", 64'(param_weight[31:0]), {32'd0, 16'hBEEF, 16'(exp_kidx - 1)});
            check("param_length", 64'(param_length), 64'(cur_len));
            check("param_width", 64'(param_width), 64'd100);
          end
        end
        if (pxl_ena_x) begin
          cnt_pxl++;
          if (cur_in != 0) begin
            cur_ic = pass_n % cur_in;
            cur_oc = pass_n / cur_in;
          end
          if (mon_en) check("src_ch", 64'(src_ch), 64'(cur_ic));
          pass_n++;
          beat = 0;
          rd_beat = 0;
        end
        if (acc_rd_en) begin
          cnt_rd++;
          if (mon_en) check("rd_addr", 64'(acc_rd_addr), 64'(rd_beat));
          rd_beat++;
        end
        if (core_ena_z && busy) begin
          cnt_z++;
          if (mon_en) begin
            if (cur_ic == cur_in - 1) begin
              check("out_en", 64'(out_en), 64'd1);
              check("wr_en_last", 64'(acc_wr_en), 64'd0);
              check("out_oc", 64'(out_oc), 64'(cur_oc));
            end else begin
              check("wr_en", 64'(acc_wr_en), 64'd1);
              check("out_en_mid", 64'(out_en), 64'd0);
              check("wr_addr", 64'(acc_wr_addr), 64'(beat));
            end
            check("pxl_y", 64'(core_pxl_y), (cur_ic == 0) ? 64'd0 : 64'(32'h5000_0000 + beat));
          end
          beat++;
        end
        if (acc_wr_en) cnt_wr++;
        if (out_en) cnt_out++;
        if (done) begin
          cnt_done++;
          done_z = cnt_z;
        end
      end
      wgt_req_d    = wgt_req;
      rd_pend      = acc_rd_en;
      rd_pend_addr = acc_rd_addr;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; src_ready = 1'b1;
    cfg_width = '0; cfg_length = '0; cfg_in_ch = '0; cfg_out_ch = '0;
    clr_counts();
    repeat (3) tick();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", 64'({done, wgt_req, param_ena, pxl_ena_x, acc_rd_en, acc_wr_en, out_en}), 64'd0);
    check("rst_addrs", 64'({wgt_addr, acc_rd_addr, acc_wr_addr, src_ch, out_oc}), 64'd0);
    check("rst_params", 64'({param_width, param_length, param_weight[31:0]}), 64'd0);
    check("rst_pxl_y", 64'(core_pxl_y), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single channel: results stream straight out with zero partial sums.
    wgt_delay = 3;
    start_layer(1, 1, 16);
    wait_done(500);
    check("t1_param", 64'(cnt_param), 64'd1);
    check("t1_pxl", 64'(cnt_pxl), 64'd1);
    check("t1_out", 64'(cnt_out), 64'd16);
    check("t1_wr", 64'(cnt_wr), 64'd0);
    check("t1_done", 64'(cnt_done), 64'd1);

    // 3 in x 2 out: accumulate twice, stream on the third channel.
    wgt_delay = 1;
    start_layer(3, 2, 4);
    wait_done(1000);
    check("t2_wreq", 64'(cnt_wreq), 64'd6);
    check("t2_param", 64'(cnt_param), 64'd6);
    check("t2_pxl", 64'(cnt_pxl), 64'd6);
    check("t2_wr", 64'(cnt_wr), 64'd16);
    check("t2_rd", 64'(cnt_rd), 64'd16);
    check("t2_out", 64'(cnt_out), 64'd8);
    check("t2_done_z", 64'(done_z), 64'd24);
    check("t2_done", 64'(cnt_done), 64'd1);

    // Empty layer: one busy cycle, then done.
    start_layer(0, 5, 4);
    check("t3_busy_fin", 64'(busy), 64'd1);
    check("t3_done_fin", 64'(done), 64'd0);
    tick();
    check("t3_busy_idle", 64'(busy), 64'd0);
    check("t3_done_pulse", 64'(done), 64'd1);
    tick();
    check("t3_done_drop", 64'(done), 64'd0);
    repeat (5) tick();
    check("t3_wreq", 64'(cnt_wreq), 64'd0);
    check("t3_done_cnt", 64'(cnt_done), 64'd1);
    start_layer(2, 0, 4);
    repeat (4) tick();
    check("t3b_done_cnt", 64'(cnt_done), 64'd1);
    check("t3b_wreq", 64'(cnt_wreq), 64'd0);

    // Abort during the second pass.
    wgt_delay = 2;
    start_layer(2, 2, 4);
    n = 0;
    while (!(cnt_pxl == 2 && cnt_z >= 5) && n < 300) begin
      tick();
      n++;
    end
    check("t4_reach_pass2", 64'(cnt_z >= 5), 64'd1);
    mon_en = 1'b0;
    cfg_abort = 1'b1;
    cfg_start = 1'b1;
    #1;
    check("t4_abort_strobes", 64'({acc_wr_en, out_en, acc_rd_en}), 64'd0);
    tick();
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_wgt_req", 64'(wgt_req), 64'd0);
    repeat (20) tick();
    check("t4_still_idle", 64'(busy), 64'd0);
    check("t4_no_done", 64'(cnt_done), 64'd0);
    mon_en = 1'b1;
    start_layer(1, 1, 4);
    wait_done(300);
    check("t4_restart_param", 64'(cnt_param), 64'd1);
    check("t4_restart_out", 64'(cnt_out), 64'd4);

    // Asynchronous reset while a fetch is outstanding.
    wgt_delay = 50;
    start_layer(2, 1, 4);
    n = 0;
    while (!wgt_req && n < 20) begin
      tick();
      n++;
    end
    check("t5_wgt_req_up", 64'(wgt_req), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_wgt_req", 64'(wgt_req), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_param", 64'({param_width, wgt_addr, src_ch}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wgt_delay = 3;
    clr_counts();
    repeat (30) tick();
    check("t5_hold_busy", 64'(busy), 64'd0);
    check("t5_hold_strobes", 64'(cnt_wreq + cnt_param + cnt_pxl), 64'd0);

    // Source stall: pass start waits for src_ready.
    src_ready = 1'b0;
    start_layer(1, 1, 2);
    n = 0;
    while (cnt_param == 0 && n < 50) begin
      tick();
      n++;
    end
    check("t6_loaded", 64'(cnt_param), 64'd1);
    repeat (50) tick();
    check("t6_pxl_held", 64'(cnt_pxl), 64'd0);
    src_ready = 1'b1;
    check("t6_pxl_same_cycle", 64'(pxl_ena_x), 64'd0);
    tick();
    check("t6_pxl_fire", 64'(pxl_ena_x), 64'd1);
    tick();
    check("t6_pxl_drop", 64'(pxl_ena_x), 64'd0);
    wait_done(200);
    check("t6_pxl_cnt", 64'(cnt_pxl), 64'd1);
    check("t6_out", 64'(cnt_out), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
